// File: rtl/issue_ctrl_pkg.sv
// Shared types and helpers for the issue scheduler: functional-unit select,
// scheduler states and the register-mask helper used by the scoreboard.
package issue_ctrl_pkg;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_LSU = 2'd1,
        FU_PC  = 2'd2
    } fu_sel;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_WAIT_LSU = 2'd1,
        S_WAIT_PC  = 2'd2
    } ictrl_state;

    // One-hot mask of a register; x0 never maps to a bit so it can never be busy.
    function automatic logic [31:0] reg_mask(input logic en, input logic [4:0] addr);
        logic [31:0] mask;
        mask = 32'd0;
        if (en && (addr != 5'd0)) begin
            mask[addr] = 1'b1;
        end else begin
            mask = 32'd0;
        end
        return mask;
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Register busy vector: one set port (issue), one clear port (writeback),
// and lookup ports for both sources and the destination.
module issue_scoreboard
    import issue_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        set_en_i,
    input  logic [4:0]  set_addr_i,
    input  logic        clr_en_i,
    input  logic [4:0]  clr_addr_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    input  logic [4:0]  rd_addr_i,
    output logic        rs1_busy_o,
    output logic        rs2_busy_o,
    output logic        rd_busy_o,
    output logic [31:0] busy_o
);

    logic [31:0] busy_r;
    logic [31:0] busy_nxt_s;

    // Clear first, then set, so a same-cycle set on the same register wins.
    always_comb begin
        busy_nxt_s = (busy_r & ~reg_mask(clr_en_i, clr_addr_i))
                   | reg_mask(set_en_i, set_addr_i);
    end

    // Busy vector register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_r <= 32'd0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign rs1_busy_o = busy_r[rs1_addr_i];
    assign rs2_busy_o = busy_r[rs2_addr_i];
    assign rd_busy_o  = busy_r[rd_addr_i];
    assign busy_o     = busy_r;

endmodule

// File: rtl/issue_ctrl.sv
// Issue scheduler: holds a decoded instruction until its registers are free
// and its unit is idle, then emits a one-cycle issue enable.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             dec_valid_i,
    output logic             dec_ready_o,
    input  logic [4:0]       rs1_addr_i,
    input  logic [4:0]       rs2_addr_i,
    input  logic             rs1_used_i,
    input  logic             rs2_used_i,
    input  logic [4:0]       rd_addr_i,
    input  logic             rd_wr_i,
    input  fu_sel            unit_i,
    output logic             issue_en_o,
    input  logic             wb_valid_i,
    input  logic [4:0]       wb_addr_i,
    input  logic             lsu_done_i,
    input  logic             pc_done_i,
    output logic [31:0]      busy_o,
    output logic [CNT_W-1:0] issued_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    ictrl_state       state_r;
    ictrl_state       state_nxt_s;
    logic             rs1_busy_s;
    logic             rs2_busy_s;
    logic             rd_busy_s;
    logic             hazard_s;
    logic             ready_s;
    logic             hs_s;
    logic             stall_s;
    logic             issue_en_r;
    logic [CNT_W-1:0] issued_cnt_r;
    logic [CNT_W-1:0] stall_cnt_r;

    issue_scoreboard u_scoreboard (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .set_en_i   (hs_s & rd_wr_i),
        .set_addr_i (rd_addr_i),
        .clr_en_i   (wb_valid_i),
        .clr_addr_i (wb_addr_i),
        .rs1_addr_i (rs1_addr_i),
        .rs2_addr_i (rs2_addr_i),
        .rd_addr_i  (rd_addr_i),
        .rs1_busy_o (rs1_busy_s),
        .rs2_busy_o (rs2_busy_s),
        .rd_busy_o  (rd_busy_s),
        .busy_o     (busy_o)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= S_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: LSU/PC issues park the scheduler until their done pulse.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_RUN: begin
                if (hs_s) begin
                    case (unit_i)
                        FU_LSU:  state_nxt_s = S_WAIT_LSU;
                        FU_PC:   state_nxt_s = S_WAIT_PC;
                        default: state_nxt_s = S_RUN;
                    endcase
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_WAIT_LSU: begin
                if (lsu_done_i) begin
                    state_nxt_s = S_RUN;
                end else begin
                    state_nxt_s = S_WAIT_LSU;
                end
            end
            S_WAIT_PC: begin
                if (pc_done_i) begin
                    state_nxt_s = S_RUN;
                end else begin
                    state_nxt_s = S_WAIT_PC;
                end
            end
            default: state_nxt_s = S_RUN;
        endcase
    end

    // Handshake decode: hazards are checked against the registered scoreboard only.
    always_comb begin
        hazard_s = (rs1_used_i & rs1_busy_s)
                 | (rs2_used_i & rs2_busy_s)
                 | (rd_wr_i & rd_busy_s);
        ready_s  = (state_r == S_RUN) & ~hazard_s;
        hs_s     = dec_valid_i & ready_s;
        stall_s  = dec_valid_i & ~ready_s;
    end

    // Issue enable pulse and wrapping performance counters.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            issue_en_r   <= 1'b0;
            issued_cnt_r <= CNT_ZERO;
            stall_cnt_r  <= CNT_ZERO;
        end else begin
            issue_en_r <= hs_s;
            if (hs_s) begin
                issued_cnt_r <= issued_cnt_r + CNT_ONE;
            end else begin
                issued_cnt_r <= issued_cnt_r;
            end
            if (stall_s) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign dec_ready_o  = ready_s;
    assign issue_en_o   = issue_en_r;
    assign issued_cnt_o = issued_cnt_r;
    assign stall_cnt_o  = stall_cnt_r;

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_issue_ctrl;
    import issue_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        dec_valid;
    logic        dec_ready;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, wb_addr;
    logic        rs1_used, rs2_used, rd_wr;
    fu_sel       unit;
    logic        issue_en;
    logic        wb_valid, lsu_done, pc_done;
    logic [31:0] busy;
    logic [31:0] issued_cnt, stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    // Behavioural model: busy bits, wait mode (0 run, 1 lsu, 2 pc), counters.
    logic [31:0] m_busy  = 32'd0;
    int          m_mode  = 0;
    logic [31:0] m_iss   = 32'd0;
    logic [31:0] m_stall = 32'd0;
    logic        m_en    = 1'b0;

    issue_ctrl #(.CNT_W(32)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .dec_valid_i  (dec_valid),
        .dec_ready_o  (dec_ready),
        .rs1_addr_i   (rs1_addr),
        .rs2_addr_i   (rs2_addr),
        .rs1_used_i   (rs1_used),
        .rs2_used_i   (rs2_used),
        .rd_addr_i    (rd_addr),
        .rd_wr_i      (rd_wr),
        .unit_i       (unit),
        .issue_en_o   (issue_en),
        .wb_valid_i   (wb_valid),
        .wb_addr_i    (wb_addr),
        .lsu_done_i   (lsu_done),
        .pc_done_i    (pc_done),
        .busy_o       (busy),
        .issued_cnt_o (issued_cnt),
        .stall_cnt_o  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit model_ready();
        bit conflict;
        conflict = (rs1_used && m_busy[rs1_addr]) || (rs2_used && m_busy[rs2_addr])
                || (rd_wr && m_busy[rd_addr]);
        return (m_mode == 0) && !conflict;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each clock edge from the inputs of the ending cycle.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 32'd0; m_mode <= 0; m_iss <= 32'd0; m_stall <= 32'd0; m_en <= 1'b0;
        end else begin
            m_en <= dec_valid && model_ready();
            if (dec_valid && !model_ready()) m_stall <= m_stall + 32'd1;
            if (wb_valid && wb_addr != 5'd0) m_busy[wb_addr] <= 1'b0;
            if (dec_valid && model_ready()) begin
                m_iss <= m_iss + 32'd1;
                if (rd_wr && rd_addr != 5'd0) m_busy[rd_addr] <= 1'b1;
                m_mode <= (unit == FU_LSU) ? 1 : (unit == FU_PC) ? 2 : 0;
            end else if ((m_mode == 1 && lsu_done) || (m_mode == 2 && pc_done)) begin
                m_mode <= 0;
            end
        end
    end

    // Compare process: DUT outputs against the model in the middle of every cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            check("ready",  {31'd0, dec_ready}, {31'd0, model_ready()});
            check("issue_en", {31'd0, issue_en}, {31'd0, m_en});
            check("busy",   busy, m_busy);
            check("issued", issued_cnt, m_iss);
            check("stalls", stall_cnt, m_stall);
        end
    end

    task automatic idle();
        dec_valid = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0; rd_addr = 5'd0;
        rs1_used = 1'b0; rs2_used = 1'b0; rd_wr = 1'b0; unit = FU_ALU;
        wb_valid = 1'b0; wb_addr = 5'd0; lsu_done = 1'b0; pc_done = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input fu_sel u, input logic [4:0] rd, input logic wr,
                      input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
        dec_valid = 1'b1; unit = u; rd_addr = rd; rd_wr = wr;
        rs1_addr = r1; rs1_used = u1; rs2_addr = r2; rs2_used = u2;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        cyc();
        do_reset();
        chk_on = 1'b1;

        // Single ALU op to x5, writeback three cycles later.
        op(FU_ALU, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        #2; check("t1_ready", {31'd0, dec_ready}, 32'd1);
        check("t1_reset_busy", busy, 32'd0);
        check("t1_reset_cnt", issued_cnt, 32'd0);
        cyc(); idle();
        #2; check("t1_busy", busy, 32'h20);
        check("t1_en", {31'd0, issue_en}, 32'd1);
        check("t1_cnt", issued_cnt, 32'd1);
        cyc(); #2; check("t1_en_off", {31'd0, issue_en}, 32'd0);
        cyc(); wb_valid = 1'b1; wb_addr = 5'd5;
        cyc(); idle();
        #2; check("t1_wb", busy, 32'd0);

        // RAW on x5, writeback in cycle 4, handshake in cycle 5.
        do_reset();
        op(FU_ALU, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc(); op(FU_ALU, 5'd6, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1);
        #2; check("t2_c2", {31'd0, dec_ready}, 32'd0);
        cyc(); #2; check("t2_c3", {31'd0, dec_ready}, 32'd0);
        cyc(); wb_valid = 1'b1; wb_addr = 5'd5;
        #2; check("t2_c4", {31'd0, dec_ready}, 32'd0);
        cyc(); wb_valid = 1'b0;
        #2; check("t2_c5", {31'd0, dec_ready}, 32'd1);
        cyc(); idle();
        #2; check("t2_stall", stall_cnt, 32'd3);
        check("t2_iss", issued_cnt, 32'd2);
        check("t2_busy", busy, 32'h40);

        // Load to x7, ALU op waiting, spurious pc_done, lsu_done 5 cycles later.
        do_reset();
        op(FU_LSU, 5'd7, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
        for (int c = 2; c <= 6; c++) begin
            cyc();
            op(FU_ALU, 5'd8, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0);
            pc_done  = (c == 3);
            lsu_done = (c == 6);
            #2; check("t3_wait", {31'd0, dec_ready}, 32'd0);
        end
        cyc(); lsu_done = 1'b0;
        #2; check("t3_after", {31'd0, dec_ready}, 32'd1);
        cyc(); idle();
        #2; check("t3_iss", issued_cnt, 32'd2);
        check("t3_stall", stall_cnt, 32'd5);
        check("t3_busy", busy, 32'h180);

        // Writeback and new issue hit x9 in the same cycle: set wins.
        do_reset();
        op(FU_ALU, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        wb_valid = 1'b1; wb_addr = 5'd9;
        cyc(); idle();
        #2; check("t4_busy9", busy, 32'h200);

        // x0 as destination and writeback never becomes busy.
        do_reset();
        op(FU_ALU, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        wb_valid = 1'b1; wb_addr = 5'd0;
        cyc(); wb_valid = 1'b0;
        op(FU_ALU, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
        #2; check("t5_ready", {31'd0, dec_ready}, 32'd1);
        check("t5_busy", busy, 32'd0);

        // Reset during S_WAIT_PC with x4..x7 busy.
        do_reset();
        for (int r = 4; r <= 7; r++) begin
            op(FU_ALU, 5'(r), 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
            cyc();
        end
        op(FU_PC, 5'd0, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0);
        cyc(); op(FU_ALU, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        #2; check("t6_busy", busy, 32'hF0);
        check("t6_wait", {31'd0, dec_ready}, 32'd0);
        rst_n = 1'b0;
        cyc(); rst_n = 1'b1;
        #2; check("t6_rst_busy", busy, 32'd0);
        check("t6_rst_en", {31'd0, issue_en}, 32'd0);
        check("t6_rst_iss", issued_cnt, 32'd0);
        check("t6_rst_stall", stall_cnt, 32'd0);
        check("t6_rst_ready", {31'd0, dec_ready}, 32'd1);
        cyc();

        // Randomized traffic on a small register window to provoke hazards.
        for (int i = 0; i < 4000; i++) begin
            dec_valid = ($urandom_range(0, 9) < 7);
            rs1_addr  = 5'($urandom_range(0, 7));
            rs2_addr  = 5'($urandom_range(0, 7));
            rd_addr   = 5'($urandom_range(0, 7));
            rs1_used  = 1'($urandom_range(0, 1));
            rs2_used  = 1'($urandom_range(0, 1));
            rd_wr     = ($urandom_range(0, 3) != 0);
            unit      = fu_sel'(2'($urandom_range(0, 9) < 6 ? 0 : $urandom_range(1, 2)));
            wb_valid  = ($urandom_range(0, 9) < 4);
            wb_addr   = 5'($urandom_range(0, 7));
            lsu_done  = ($urandom_range(0, 3) == 0);
            pc_done   = ($urandom_range(0, 3) == 0);
            rst_n     = ($urandom_range(0, 299) != 0);
            cyc();
        end
        rst_n = 1'b1;
        idle();
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_ctrl.md
# issue_ctrl

Issue scheduler sitting between decode and the `issue` stage. Holds each decoded instruction until its source and destination registers are free and the target unit (ALU, LSU, PC_ALU) can accept it. It then produces the one-cycle enable pulse that makes `issue` latch its operands. A 31-entry register scoreboard handles RAW/WAW hazards. A small FSM serialises LSU and PC_ALU operations.

## Interface
Parameters:
- `CNT_W`, 32, width of performance counters

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  synchronous reset, active low
- `dec_valid_i`  in  1  decoded instruction available
- `dec_ready_o`  out  1  controller accepts instruction this cycle
- `rs1_addr_i`, `rs2_addr_i`  in  5  source registers
- `rs1_used_i`, `rs2_used_i`  in  1  source actually read
- `rd_addr_i`  in  5  destination register
- `rd_wr_i`  in  1  instruction writes `rd`
- `unit_i`  in  `pkg::fu_sel`  target unit: FU_ALU, FU_LSU or FU_PC
- `issue_en_o`  out  1  enable pulse to `issue.en_i`
- `wb_valid_i`  in  1  register file write completes
- `wb_addr_i`  in  5  register written
- `lsu_done_i`  in  1  outstanding memory op finished
- `pc_done_i`  in  1  PC_ALU result (jump/branch) resolved
- `busy_o`  out  32  scoreboard; bit 0 always 0
- `issued_cnt_o`  out  CNT_W  instructions issued
- `stall_cnt_o`  out  CNT_W  cycles with `dec_valid_i` high and `dec_ready_o` low

## Operation
- FSM states:
  - S_RUN: accepts instructions.
  - S_WAIT_LSU: an LSU op is outstanding.
  - S_WAIT_PC: a control-flow op is outstanding.
- Hazard (combinational, uses the registered scoreboard, no bypass):
  - `(rs1_used_i & busy[rs1])`, or
  - `(rs2_used_i & busy[rs2])`, or
  - `(rd_wr_i & busy[rd])`.
- `dec_ready_o` = state==S_RUN & !hazard. Handshake = `dec_valid_i & dec_ready_o`.
- On handshake:
  - `busy[rd]` is set if `rd_wr_i` and rd≠0.
  - `issued_cnt_o` increments.
  - Next state: FU_LSU goes to S_WAIT_LSU, FU_PC goes to S_WAIT_PC, FU_ALU stays in S_RUN.
- `wb_valid_i` clears `busy[wb_addr_i]`. Writeback to x0 is ignored.
- If a set and a clear hit the same register in the same cycle, the set wins.
- S_WAIT_LSU returns to S_RUN on `lsu_done_i`. S_WAIT_PC returns to S_RUN on `pc_done_i`. A done pulse received in any other state is ignored.
- Counters wrap modulo 2^CNT_W.
- Reset values (any cycle, including mid-operation):
  - state = S_RUN
  - `busy_o` = 0
  - `issue_en_o` = 0
  - both counters = 0
  - `dec_ready_o` follows from these values.

## Timing
- `issue_en_o` is registered. It is high for exactly the one cycle after the handshake, so `issue` latches on its rising edge.
- Decode must hold operands and immediates stable through that cycle.
- Back-to-back ALU ops with no hazard: one issue per cycle, and `issue_en_o` stays high continuously. `issue` must therefore treat `issue_en_o` as a per-cycle qualifier.
- RAW on a register cleared by `wb_valid_i` in cycle N: earliest handshake is cycle N+1.
- After an LSU or PC issue, `dec_ready_o` is low from the cycle after the handshake until the cycle after the done pulse.
- `stall_cnt_o` increments in every cycle where `dec_valid_i` is high and `dec_ready_o` is low, including the wait states.

## Structure
- `pkg` additions:
  - `typedef enum logic [1:0] {FU_ALU, FU_LSU, FU_PC} fu_sel`
  - `typedef enum logic [1:0] {S_RUN, S_WAIT_LSU, S_WAIT_PC} ictrl_state`
- Sub-module `issue_scoreboard` holds the 32-bit busy vector, with a set port, a clear port, and two read ports plus a `rd` check port. The FSM and counters stay in `issue_ctrl`.

## Test plan
- ALU op with rd=x5, then `wb_valid_i` for x5 three cycles later.
  - Expect `busy_o`=0x20 after the handshake, then 0 after writeback.
  - `issue_en_o` is a single pulse; `issued_cnt_o`=1.
- `add x5` followed by `add x6,x5,x1` with writeback of x5 in cycle 4.
  - `dec_ready_o` is low in cycles 2–4, the handshake occurs in cycle 5, and `stall_cnt_o`=3.
- Load to x7, then `lsu_done_i` 5 cycles later while a second ALU op is waiting.
  - No handshake during S_WAIT_LSU.
  - The second op issues the cycle after done.
  - A spurious `pc_done_i` during the wait has no effect.
- Writeback of x9 in the same cycle as a new issue writing x9.
  - Expect `busy[9]`=1 afterwards.
- Write to x0 and writeback to x0.
  - `busy_o[0]` stays 0, and an op with rs1=x0 is never stalled.
- Assert `rst_ni`=0 during S_WAIT_PC with `busy_o`=0xF0.
  - Next cycle: state is S_RUN, `busy_o`=0, counters are 0, and `issue_en_o`=0.
